// File: rtl/alu_seq.sv
// Sequential ALU: LUT logic/arith in one EXEC cycle, serial shifts, optional shift-add multiplier.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier; otherwise op 101 is reported via err.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [2:0]       op,
    input  logic [3:0]       lut,
    input  logic             ls,
    input  logic             cin,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             valid,
    output logic             err,
    output logic [3:0]       psr
);

    localparam logic [2:0] OP_LOGIC = 3'b000;
    localparam logic [2:0] OP_ARITH = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [SHAMT_W-1:0] MUL_CNT = SHAMT_W'(WIDTH - 1);
`endif
    localparam logic [SHAMT_W:0] W_EXT = (SHAMT_W + 1)'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] lut_fn(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [3:0]       l);
        logic [WIDTH-1:0] z;
        for (int i = 0; i < WIDTH; i++) begin
            z[i] = l[{x[i], y[i]}];
        end
        return z;
    endfunction

    state_t             r_state;
    logic               r_ready;
    logic               r_valid;
    logic               r_err;
    logic [WIDTH-1:0]   r_res;
    logic [3:0]         r_psr;

    logic [2:0]         r_op;
    logic [3:0]         r_lut;
    logic               r_ls;
    logic               r_cin;
    logic               r_fwe;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_k0;
    logic [WIDTH-1:0]   r_sh;
    logic               r_shc;

    logic [SHAMT_W-1:0] w_bk;
    logic [SHAMT_W-1:0] w_k;
    logic [WIDTH-1:0]   w_f;
    logic [WIDTH-1:0]   w_ap;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic               w_shc_nxt;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_psr;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   r_mhi;
    logic [WIDTH-1:0]   r_mlo;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH-1:0]   w_mhi_nxt;
    logic [WIDTH-1:0]   w_mlo_nxt;
    logic [WIDTH-1:0]   w_hi;

    // Shift-add step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    always_comb begin
        w_madd    = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_a} : '0);
        w_mhi_nxt = w_madd[WIDTH:1];
        w_mlo_nxt = {w_madd[0], r_mlo[WIDTH-1:1]};
    end
`endif

    // Shift count is reduced mod WIDTH; one subtraction suffices because b's field is below 2*WIDTH.
    assign w_bk = b[SHAMT_W-1:0];
    assign w_k  = ({1'b0, w_bk} >= W_EXT) ? (w_bk - W_EXT[SHAMT_W-1:0]) : w_bk;

    always_comb begin
        w_f   = lut_fn(r_a, r_b, r_lut);
        w_ap  = r_ls ? '0 : r_a;
        w_sum = {1'b0, w_ap} + {1'b0, w_f} + {{WIDTH{1'b0}}, r_cin};

        w_sh_nxt  = r_sh;
        w_shc_nxt = r_shc;
        if (!r_k0) begin
            case (r_op)
                OP_SHL: begin
                    w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
                    w_shc_nxt = r_sh[WIDTH-1];
                end
                OP_SHR: begin
                    w_sh_nxt  = {1'b0, r_sh[WIDTH-1:1]};
                    w_shc_nxt = r_sh[0];
                end
                OP_SAR: begin
                    w_sh_nxt  = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                    w_shc_nxt = r_sh[0];
                end
                default: ;
            endcase
        end
    end

    // Final-cycle result and flags, valid only on the last EXEC cycle.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_hi  = '0;
`endif
        case (r_op)
            OP_LOGIC: w_res = w_f;
            OP_ARITH: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_ap[WIDTH-1] == w_f[WIDTH-1]) && (w_sum[WIDTH-1] != w_ap[WIDTH-1]);
            end
            OP_SHL, OP_SHR, OP_SAR: begin
                w_res = w_sh_nxt;
                w_c   = w_shc_nxt;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                w_res = w_mlo_nxt;
                w_hi  = w_mhi_nxt;
                w_c   = |w_mhi_nxt;
            end
`endif
            default: w_err = 1'b1;
        endcase
        w_psr = {w_v, (w_res == '0), w_res[WIDTH-1], w_c};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_res    <= '0;
            r_psr    <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_res_hi <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    if (start) begin
                        r_state <= S_EXEC;
                        r_ready <= 1'b0;
                        r_op    <= op;
                        r_lut   <= lut;
                        r_ls    <= ls;
                        r_cin   <= cin;
                        r_fwe   <= flag_we;
                        r_a     <= a;
                        r_b     <= b;
                        r_sh    <= a;
                        r_shc   <= 1'b0;
                        r_k0    <= (w_k == '0);
`ifdef ALU_SEQ_MUL_EN
                        r_mhi   <= '0;
                        r_mlo   <= b;
`endif
                        case (op)
                            OP_SHL, OP_SHR, OP_SAR:
                                r_cnt <= (w_k == '0) ? '0 : (w_k - SHAMT_W'(1));
`ifdef ALU_SEQ_MUL_EN
                            OP_MUL: r_cnt <= MUL_CNT;
`endif
                            default: r_cnt <= '0;
                        endcase
                    end
                end
                S_EXEC: begin
                    r_sh  <= w_sh_nxt;
                    r_shc <= w_shc_nxt;
`ifdef ALU_SEQ_MUL_EN
                    r_mhi <= w_mhi_nxt;
                    r_mlo <= w_mlo_nxt;
`endif
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_err   <= w_err;
                        r_res   <= w_res;
`ifdef ALU_SEQ_MUL_EN
                        r_res_hi <= w_hi;
`endif
                        if (r_fwe && !w_err) begin
                            r_psr <= w_psr;
                        end
                    end else begin
                        r_cnt <= r_cnt - SHAMT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign valid  = r_valid;
    assign err    = r_err;
    assign result = r_res;
    assign psr    = r_psr;
`ifdef ALU_SEQ_MUL_EN
    assign result_hi = r_res_hi;
`else
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: predictions queued at accept, compared when valid pulses.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [2:0] op;
    logic [3:0] lut;
    logic       ls;
    logic       cin;
    logic       flag_we;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       valid;
    logic       err;
    logic [3:0] psr;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .op        (op),
        .lut       (lut),
        .ls        (ls),
        .cin       (cin),
        .flag_we   (flag_we),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .valid     (valid),
        .err       (err),
        .psr       (psr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] psr;
        logic       err;
        int         lat;
        int         c0;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] m_psr = 4'h0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic [2:0] p_op, input logic [3:0] p_lut, input logic p_ls,
                           input logic p_cin, input logic p_fwe, input logic [7:0] p_a,
                           input logic [7:0] p_b, output exp_t e);
        logic [7:0]  f;
        logic [7:0]  ap;
        logic [15:0] p;
        int          k;
        int          s;
        int          ss;
        logic        c;
        logic        v;
        for (int i = 0; i < 8; i++)
            f[i] = p_a[i] ? (p_b[i] ? p_lut[3] : p_lut[2]) : (p_b[i] ? p_lut[1] : p_lut[0]);
        k = int'(p_b[2:0]);
        c = 1'b0;
        v = 1'b0;
        e.res = 8'h00;
        e.hi  = 8'h00;
        e.err = 1'b0;
        e.lat = 1;
        e.c0  = 0;
        p     = 16'h0;
        case (p_op)
            3'b000: e.res = f;
            3'b001: begin
                ap = p_ls ? 8'h00 : p_a;
                s  = int'(ap) + int'(f) + int'(p_cin);
                ss = int'($signed(ap)) + int'($signed(f)) + int'(p_cin);
                e.res = s[7:0];
                c = s[8];
                v = (ss > 127) || (ss < -128);
            end
            3'b010: begin
                e.res = p_a << k;
                c = (k != 0) ? p_a[8-k] : 1'b0;
                e.lat = (k == 0) ? 1 : k;
            end
            3'b011: begin
                e.res = p_a >> k;
                c = (k != 0) ? p_a[k-1] : 1'b0;
                e.lat = (k == 0) ? 1 : k;
            end
            3'b100: begin
                e.res = 8'($signed(p_a) >>> k);
                c = (k != 0) ? p_a[k-1] : 1'b0;
                e.lat = (k == 0) ? 1 : k;
            end
`ifdef ALU_SEQ_MUL_EN
            3'b101: begin
                p = p_a * p_b;
                e.res = p[7:0];
                e.hi  = p[15:8];
                c = (p[15:8] != 8'h00);
                e.lat = 8;
            end
`endif
            default: e.err = 1'b1;
        endcase
        if (!e.err && p_fwe) m_psr = {v, (e.res == 8'h00), e.res[7], c};
        e.psr = m_psr;
    endtask

    task automatic issue(input logic [2:0] t_op, input logic [3:0] t_lut, input logic t_ls,
                         input logic t_cin, input logic t_fwe, input logic [7:0] t_a,
                         input logic [7:0] t_b, input int hold, input bit track);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_timeout", 32'(ready), 1);
            return;
        end
        op = t_op; lut = t_lut; ls = t_ls; cin = t_cin; flag_we = t_fwe; a = t_a; b = t_b;
        start = 1'b1;
        if (track) predict(t_op, t_lut, t_ls, t_cin, t_fwe, t_a, t_b, e);
        @(posedge clk);
        #1;
        if (track) begin
            e.c0 = cyc;
            sb.push_back(e);
        end
        // Scramble inputs after accept; the DUT must have captured them already.
        op = 3'($urandom_range(0, 7)); lut = 4'($urandom_range(0, 15));
        a = 8'($urandom); b = 8'($urandom); cin = ~t_cin; ls = ~t_ls; flag_we = ~t_fwe;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result",    32'(result),    32'(mon_e.res));
                check("result_hi", 32'(result_hi), 32'(mon_e.hi));
                check("psr",       32'(psr),       32'(mon_e.psr));
                check("err",       32'(err),       32'(mon_e.err));
                check("latency",   32'(cyc - mon_e.c0), 32'(mon_e.lat));
                check("ready_in_done", 32'(ready), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 3'b000; lut = 4'h0; ls = 1'b0; cin = 1'b0;
        flag_we = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(ready),     1);
        check("rst_valid",  32'(valid),     0);
        check("rst_err",    32'(err),       0);
        check("rst_result", 32'(result),    0);
        check("rst_hi",     32'(result_hi), 0);
        check("rst_psr",    32'(psr),       0);
        reset = 1'b0;

        issue(3'b001, 4'b1010, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 0, 1'b1);
        issue(3'b001, 4'b0101, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05, 0, 1'b1);
        issue(3'b001, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 0, 1'b1);
        issue(3'b001, 4'b1010, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h7F, 0, 1'b1);
        issue(3'b000, 4'b0110, 1'b0, 1'b0, 1'b1, 8'hCC, 8'hAA, 0, 1'b1);
        issue(3'b000, 4'b1000, 1'b0, 1'b0, 1'b1, 8'hCC, 8'h33, 0, 1'b1);
        issue(3'b010, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h03, 0, 1'b1);
        issue(3'b011, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h01, 0, 1'b1);
        issue(3'b100, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h02, 0, 1'b1);
        issue(3'b010, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h00, 0, 1'b1);
        issue(3'b010, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h0B, 0, 1'b1);
        issue(3'b100, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h07, 0, 1'b1);
        issue(3'b101, 4'h0,    1'b0, 1'b0, 1'b1, 8'h0F, 8'h11, 0, 1'b1);
        issue(3'b101, 4'h0,    1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 0, 1'b1);
        issue(3'b111, 4'hF,    1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 0, 1'b1);
        issue(3'b110, 4'hF,    1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b1);
        // start kept high through EXEC must not produce a second accept
        issue(3'b010, 4'h0,    1'b0, 1'b0, 1'b1, 8'h81, 8'h03, 2, 1'b1);

        for (int i = 0; i < 24; i++)
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  0, 1'b1);

        // Abort a long op with reset three cycles in
        issue(3'b001, 4'b1010, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 0, 1'b1);
`ifdef ALU_SEQ_MUL_EN
        issue(3'b101, 4'h0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 0, 1'b0);
`else
        issue(3'b010, 4'h0, 1'b0, 1'b0, 1'b1, 8'h81, 8'h07, 0, 1'b0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready",  32'(ready),  1);
        check("abort_valid",  32'(valid),  0);
        check("abort_psr",    32'(psr),    0);
        check("abort_result", 32'(result), 0);
        reset = 1'b0;
        m_psr = 4'h0;
        issue(3'b001, 4'b0101, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05, 0, 1'b1);
        issue(3'b001, 4'b1010, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 0, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
